// File: rtl/fx_reg_bank.sv
// fx-bus slave register bank: ID/VER, CTRL, SCRATCH, sticky STATUS and a
// 32-bit microsecond counter whose upper bytes are read through a snapshot.
module fx_reg_bank #(
  parameter logic [7:0] DEV_ID  = 8'h5A,
  parameter logic [7:0] DEV_VER = 8'h01,
  parameter logic [7:0] CLR_KEY = 8'hA5
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [15:0] fx_waddr,
  input  logic        fx_wr,
  input  logic [7:0]  fx_data,
  input  logic        fx_rd,
  input  logic [15:0] fx_raddr,
  output logic [7:0]  fx_q,
  input  logic        evt_in,
  output logic [7:0]  ctrl_out
);

  localparam logic [15:0] ADDR_ID      = 16'h0000;
  localparam logic [15:0] ADDR_VER     = 16'h0001;
  localparam logic [15:0] ADDR_CTRL    = 16'h0002;
  localparam logic [15:0] ADDR_SCRATCH = 16'h0003;
  localparam logic [15:0] ADDR_STATUS  = 16'h0004;
  localparam logic [15:0] ADDR_US0     = 16'h0010;
  localparam logic [15:0] ADDR_US1     = 16'h0011;
  localparam logic [15:0] ADDR_US2     = 16'h0012;
  localparam logic [15:0] ADDR_US3     = 16'h0013;

  logic [7:0]  ctrl_reg;
  logic [7:0]  scratch_reg;
  logic        evt_seen;
  logic        cnt_wrap;
  logic        evt_d;
  logic [31:0] us_cnt;
  logic [31:0] snapshot;
  logic [7:0]  rd_data;

  logic wr_ctrl, wr_scratch, cnt_clr, cnt_inc, wrap_evt;
  logic evt_rise, status_rd, snap_ld;

  assign wr_ctrl    = fx_wr && (fx_waddr == ADDR_CTRL);
  assign wr_scratch = fx_wr && (fx_waddr == ADDR_SCRATCH);
  assign cnt_clr    = fx_wr && (fx_waddr == ADDR_US0) && (fx_data == CLR_KEY);
  assign cnt_inc    = pluse_us && ctrl_reg[0];
  // A clear beats a same-cycle increment, so it can never count as a wrap.
  assign wrap_evt   = cnt_inc && !cnt_clr && (us_cnt == 32'hFFFF_FFFF);
  assign evt_rise   = evt_in && !evt_d;
  assign status_rd  = fx_rd && (fx_raddr == ADDR_STATUS);
  assign snap_ld    = fx_rd && (fx_raddr == ADDR_US0);
  assign ctrl_out   = ctrl_reg;

  always_comb begin
    rd_data = 8'h00;
    case (fx_raddr)
      ADDR_ID:      rd_data = DEV_ID;
      ADDR_VER:     rd_data = DEV_VER;
      ADDR_CTRL:    rd_data = ctrl_reg;
      ADDR_SCRATCH: rd_data = scratch_reg;
      ADDR_STATUS:  rd_data = {6'b000000, cnt_wrap, evt_seen};
      ADDR_US0:     rd_data = us_cnt[7:0];
      ADDR_US1:     rd_data = snapshot[15:8];
      ADDR_US2:     rd_data = snapshot[23:16];
      ADDR_US3:     rd_data = snapshot[31:24];
      default:      rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= 8'h00;
      scratch_reg <= 8'h00;
    end else begin
      if (wr_ctrl)    ctrl_reg    <= fx_data;
      if (wr_scratch) scratch_reg <= fx_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt   <= 32'h0000_0000;
      snapshot <= 32'h0000_0000;
    end else begin
      if (cnt_clr)      us_cnt <= 32'h0000_0000;
      else if (cnt_inc) us_cnt <= us_cnt + 32'd1;
      if (snap_ld)      snapshot <= us_cnt;
    end
  end

  // Sticky flags: a set arriving on the clearing read's edge wins.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      evt_d    <= 1'b0;
      evt_seen <= 1'b0;
      cnt_wrap <= 1'b0;
    end else begin
      evt_d    <= evt_in;
      evt_seen <= evt_rise || (evt_seen && !status_rd);
      cnt_wrap <= wrap_evt || (cnt_wrap && !status_rd);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)     fx_q <= 8'h00;
    else if (fx_rd) fx_q <= rd_data;
  end

endmodule

// File: tb/tb_fx_reg_bank.sv
// Directed bench for fx_reg_bank: register map, counter/snapshot, sticky
// STATUS flags and asynchronous reset, checked against hand-computed values.
module tb_fx_reg_bank;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us;
  logic [15:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        evt_in;
  logic [7:0]  ctrl_out;

  int checks   = 0;
  int failures = 0;

  fx_reg_bank dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .evt_in   (evt_in),
    .ctrl_out (ctrl_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Drive one cycle of bus activity at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] waddr, input logic [7:0] data,
                               input logic rd, input logic [15:0] raddr,
                               input logic pulse, input logic evt);
    @(negedge clk_sys);
    fx_wr    = wr;
    fx_waddr = waddr;
    fx_data  = data;
    fx_rd    = rd;
    fx_raddr = raddr;
    pluse_us = pulse;
    evt_in   = evt;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [15:0] addr, input logic [7:0] expected);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, addr, 1'b0, 1'b0);
    checkOutput(tag, fx_q, expected);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic doPulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
      doIdle();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pluse_us = 1'b0;
    fx_waddr = 16'h0000;
    fx_wr    = 1'b0;
    fx_data  = 8'h00;
    fx_rd    = 1'b0;
    fx_raddr = 16'h0000;
    evt_in   = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checkOutput("reset_fx_q", fx_q, 8'h00);
    checkOutput("reset_ctrl_out", ctrl_out, 8'h00);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Identity registers, back-to-back reads, and fx_q holding between reads.
    doRead("read_id", 16'h0000, 8'h5A);
    doRead("read_ver", 16'h0001, 8'h01);
    doIdle();
    checkOutput("hold_ver", fx_q, 8'h01);
    doRead("read_status_reset", 16'h0004, 8'h00);
    checkOutput("ctrl_out_idle", ctrl_out, 8'h00);

    // Scratch, read-only, unmapped and full-decode checks.
    doWrite(16'h0003, 8'h3C);
    doRead("scratch_rw", 16'h0003, 8'h3C);
    doWrite(16'h0000, 8'hFF);
    doRead("id_readonly", 16'h0000, 8'h5A);
    doRead("unmapped_read", 16'h1234, 8'h00);
    doWrite(16'h0103, 8'h55);
    doRead("alias_write_ignored", 16'h0003, 8'h3C);
    applyStimulus(1'b1, 16'h0003, 8'h77, 1'b1, 16'h0003, 1'b0, 1'b0);
    checkOutput("rd_wr_same_old", fx_q, 8'h3C);
    doRead("rd_wr_same_new", 16'h0003, 8'h77);

    // Counter: 300 pulses = 0x12C, then 260 more = 0x230 while the snapshot keeps 0x12C.
    doWrite(16'h0002, 8'h81);
    checkOutput("ctrl_out_81", ctrl_out, 8'h81);
    doPulses(300);
    doRead("us0_300", 16'h0010, 8'h2C);
    doPulses(260);
    doRead("us1_snapshot", 16'h0011, 8'h01);
    doPulses(1);
    doRead("us2_snapshot", 16'h0012, 8'h00);
    doRead("us3_snapshot", 16'h0013, 8'h00);
    checkOutput("ctrl_out_hold", ctrl_out, 8'h81);

    // Wrong key and non-zero byte addresses leave the counter alone (0x231).
    doWrite(16'h0010, 8'h12);
    doWrite(16'h0011, 8'hA5);
    doRead("us0_no_clear", 16'h0010, 8'h31);
    applyStimulus(1'b1, 16'h0010, 8'hA5, 1'b0, 16'h0000, 1'b1, 1'b0);
    doRead("snapshot_survives_clear", 16'h0011, 8'h02);
    doRead("us0_cleared", 16'h0010, 8'h00);

    // Wrap: hold the counter at all-ones across one counting edge.
    @(negedge clk_sys);
    force dut.us_cnt = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    release dut.us_cnt;
    doRead("status_wrap", 16'h0004, 8'h02);
    doRead("status_wrap_cleared", 16'h0004, 8'h00);
    doWrite(16'h0010, 8'hA5);
    doRead("us0_after_wrap_clear", 16'h0010, 8'h00);

    // Event flag, then a new rising edge landing on the clearing read.
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    doIdle();
    doIdle();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0004, 1'b0, 1'b1);
    checkOutput("status_evt_collide", fx_q, 8'h01);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0004, 1'b0, 1'b1);
    checkOutput("status_evt_set_wins", fx_q, 8'h01);
    doRead("status_evt_cleared", 16'h0004, 8'h00);

    // Load state ahead of a mid-sequence reset.
    doPulses(3);
    doRead("us0_before_reset", 16'h0010, 8'h03);
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    doIdle();
    doRead("id_before_reset", 16'h0000, 8'h5A);

    @(negedge clk_sys);
    fx_rd    = 1'b1;
    fx_raddr = 16'h0003;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_fx_q", fx_q, 8'h00);
    checkOutput("async_reset_ctrl_out", ctrl_out, 8'h00);
    @(posedge clk_sys);
    #1;
    checkOutput("pending_read_dropped", fx_q, 8'h00);
    @(negedge clk_sys);
    fx_rd = 1'b0;
    rst_n = 1'b1;

    doRead("post_reset_id", 16'h0000, 8'h5A);
    doRead("post_reset_scratch", 16'h0003, 8'h00);
    doRead("post_reset_ctrl", 16'h0002, 8'h00);
    doRead("post_reset_status", 16'h0004, 8'h00);
    doPulses(2);
    doRead("post_reset_us0", 16'h0010, 8'h00);
    doRead("post_reset_us1", 16'h0011, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
